difftest_commit_queue: RTL

Commit-trace buffer between the core's debug commit port (`debug_commit_*` from `cpu_top`) and the difftest commit/trap consumers in the simulation top. It captures every retired instruction into a small first-word-fall-through FIFO and presents one record per handshake downstream. It keeps the 64-bit cycle and delivered-instruction counters and raises a sticky trap event when a designated halt instruction is delivered. The core cannot be stalled, so overflow is detected and flagged rather than back-pressured.

---
 rtl/difftest_commit_queue.sv | 131 +++++++++++++
 1 files changed

// File: rtl/difftest_commit_queue.sv
// Commit-trace FIFO between the core's debug commit port and the difftest consumers.
// Captures retired instructions, delivers one record per handshake, tracks counters and the trap event.
module difftest_commit_queue #(
   parameter int          DEPTH      = 8,
   parameter logic [31:0] TRAP_INSTR = 32'h80000000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        commit_valid,
   input  logic [31:0] commit_pc,
   input  logic [31:0] commit_instr,
   input  logic        commit_wreg,
   input  logic [4:0]  commit_waddr,
   input  logic [31:0] commit_wdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic [31:0] out_wdata,
   output logic        out_wen,
   output logic [4:0]  out_wdest,
   output logic [63:0] cycle_cnt,
   output logic [63:0] instr_cnt,
   output logic        trap_valid,
   output logic [31:0] trap_pc,
   output logic [31:0] trap_code,
   output logic        overflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);
   localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);

   // Handshake: a record transfers on every edge where out_valid && out_ready;
   // out_valid never depends on out_ready, and the head stays stable until it transfers.
   // The producer side has no ready: commits arriving while full (and not popping) are dropped.

   logic [31:0] mem_pc    [DEPTH];
   logic [31:0] mem_instr [DEPTH];
   logic        mem_wreg  [DEPTH];
   logic [4:0]  mem_waddr [DEPTH];
   logic [31:0] mem_wdata [DEPTH];

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic [31:0]   r4_shadow;

   logic empty;
   logic full;
   logic pop;
   logic push;
   logic drop;

   always_comb begin
      empty     = (count == '0);
      full      = (count == FULL_COUNT);
      out_valid = !empty && !trap_valid;
      pop       = out_valid && out_ready;
      push      = reset_n && commit_valid && (!full || pop);
      drop      = reset_n && commit_valid && full && !pop;
   end

   // Fall-through head; contents are meaningless while out_valid is low.
   always_comb begin
      out_pc    = mem_pc[rd_ptr];
      out_instr = mem_instr[rd_ptr];
      out_wdata = mem_wdata[rd_ptr];
      out_wdest = mem_waddr[rd_ptr];
      out_wen   = mem_wreg[rd_ptr] && (mem_waddr[rd_ptr] != 5'd0);
   end

   // Storage is never cleared; only the pointers and count define what is live.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_pc[wr_ptr]    <= commit_pc;
         mem_instr[wr_ptr] <= commit_instr;
         mem_wreg[wr_ptr]  <= commit_wreg;
         mem_waddr[wr_ptr] <= commit_waddr;
         mem_wdata[wr_ptr] <= commit_wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cycle_cnt <= 64'd0;
         instr_cnt <= 64'd0;
         overflow  <= 1'b0;
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
         if (pop)  instr_cnt <= instr_cnt + 64'd1;
         if (drop) overflow  <= 1'b1;
      end
   end

   // trap_code captures the shadow as it was before the trap record's own r4 write.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r4_shadow  <= 32'd0;
         trap_valid <= 1'b0;
         trap_pc    <= 32'd0;
         trap_code  <= 32'd0;
      end else if (pop) begin
         if (mem_wreg[rd_ptr] && (mem_waddr[rd_ptr] == 5'd4))
            r4_shadow <= mem_wdata[rd_ptr];
         if (mem_instr[rd_ptr] == TRAP_INSTR) begin
            trap_valid <= 1'b1;
            trap_pc    <= mem_pc[rd_ptr];
            trap_code  <= r4_shadow;
         end
      end
   end

endmodule
